// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: issues two INTA pulses under LOCK_N, then
// captures the interrupt vector and holds it until the consumer acknowledges.
module inta_sequencer #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INT,
    input  logic       IF_EN,
    input  logic [7:0] DATA_IN,
    input  logic       VECTOR_ACK,
    output logic       INTA,
    output logic       LOCK_N,
    output logic [7:0] VECTOR,
    output logic       VECTOR_VALID,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_GAP  = 3'd2,
        S_P2   = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Counter is loaded with width-1 on entry so a phase lasts exactly its width.
    localparam logic [3:0] PULSE_RELOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_RELOAD   = 4'(GAP_W - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       inta_q, inta_d;
    logic       lock_n_q, lock_n_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic [7:0] vector_q, vector_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            inta_q   <= 1'b1;
            lock_n_q <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_q   <= inta_d;
            lock_n_q <= lock_n_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            vector_q <= vector_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inta_d   = inta_q;
        lock_n_d = lock_n_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        vector_d = vector_q;

        case (state_q)
            S_IDLE: begin
                if (INT && IF_EN && !valid_q) begin
                    state_d  = S_P1;
                    cnt_d    = PULSE_RELOAD;
                    inta_d   = 1'b0;
                    lock_n_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_P1: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_RELOAD;
                    inta_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_P2;
                    cnt_d   = PULSE_RELOAD;
                    inta_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_P2: begin
                if (cnt_q == '0) begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    inta_d   = 1'b1;
                    lock_n_d = 1'b1;
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                    vector_d = DATA_IN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (VECTOR_ACK) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                inta_d   = 1'b1;
                lock_n_d = 1'b1;
                busy_d   = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    assign INTA         = inta_q;
    assign LOCK_N       = lock_n_q;
    assign BUSY         = busy_q;
    assign VECTOR_VALID = valid_q;
    assign VECTOR       = vector_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default instance plus a PULSE_W=1/GAP_W=3
// instance; expected vectors are queued at request time and popped on capture.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       int1 = 1'b0, int2 = 1'b0;
    logic       if_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       ack1 = 1'b0, ack2 = 1'b0;

    logic       inta1, lock_n1, valid1, busy1;
    logic [7:0] vector1;
    logic       inta2, lock_n2, valid2, busy2;
    logic [7:0] vector2;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    inta_sequencer u_dut1 (
        .CLK(clk), .RST_N(rst_n), .INT(int1), .IF_EN(if_en), .DATA_IN(data_in),
        .VECTOR_ACK(ack1), .INTA(inta1), .LOCK_N(lock_n1), .VECTOR(vector1),
        .VECTOR_VALID(valid1), .BUSY(busy1)
    );

    inta_sequencer #(.PULSE_W(1), .GAP_W(3)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .INT(int2), .IF_EN(if_en), .DATA_IN(data_in),
        .VECTOR_ACK(ack2), .INTA(inta2), .LOCK_N(lock_n2), .VECTOR(vector2),
        .VECTOR_VALID(valid2), .BUSY(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output bundle {inta, lock_n, busy, valid, vector} for the selected instance.
    function automatic logic [11:0] outs(input int sel);
        if (sel == 1) return {inta1, lock_n1, busy1, valid1, vector1};
        return {inta2, lock_n2, busy2, valid2, vector2};
    endfunction

    task automatic set_int(input int sel, input logic v);
        if (sel == 1) int1 = v; else int2 = v;
    endtask

    task automatic set_ack(input int sel, input logic v);
        if (sel == 1) ack1 = v; else ack2 = v;
    endtask

    // Raises INT, lets the next edge sample it, then checks the whole pulse
    // train and the captured vector at the model's latency.
    task automatic run_seq(input int sel, input int pw, input int gw,
                           input logic [7:0] data, input bit drop_int);
        logic [11:0] o;
        logic [7:0]  exp_v;
        data_in = data;
        exp_q.push_back(data);
        set_int(sel, 1'b1);
        tick();
        for (int k = 0; k < 2 * pw + gw; k++) begin
            o = outs(sel);
            check($sformatf("inta[%0d]", k), 32'(o[11]), (k >= pw && k < pw + gw) ? 32'd1 : 32'd0);
            check($sformatf("lock_n[%0d]", k), 32'(o[10]), 32'd0);
            check($sformatf("busy[%0d]", k), 32'(o[9]), 32'd1);
            check($sformatf("valid_early[%0d]", k), 32'(o[8]), 32'd0);
            if (drop_int && k == 0) set_int(sel, 1'b0);
            tick();
        end
        o = outs(sel);
        check("valid_at_latency", 32'(o[8]), 32'd1);
        check("inta_hold", 32'(o[11]), 32'd1);
        check("lock_n_hold", 32'(o[10]), 32'd1);
        check("busy_hold", 32'(o[9]), 32'd0);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_v = exp_q.pop_front();
            check("vector", 32'(o[7:0]), 32'(exp_v));
        end
    endtask

    task automatic ack_vector(input int sel);
        set_ack(sel, 1'b1);
        tick();
        set_ack(sel, 1'b0);
        check("valid_cleared", 32'(outs(sel) >> 8 & 12'h1), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_inta", 32'(inta1), 32'd1);
        check("rst_lock_n", 32'(lock_n1), 32'd1);
        check("rst_vector", 32'(vector1), 32'h00);
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Default timing, vector 8'h48.
        if_en = 1'b1;
        run_seq(1, 2, 2, 8'h48, 1'b0);

        // Vector held while ACK withheld; INT still high must not restart.
        data_in = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(valid1), 32'd1);
            check("hold_vector", 32'(vector1), 32'h48);
            check("hold_inta", 32'(inta1), 32'd1);
        end
        ack_vector(1);
        check("ack_idle_inta", 32'(inta1), 32'd1);
        run_seq(1, 2, 2, 8'h3C, 1'b0);
        int1 = 1'b0;
        ack_vector(1);

        // Requests masked by IF_EN.
        if_en = 1'b0;
        int1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("masked_inta", 32'(inta1), 32'd1);
            check("masked_lock_n", 32'(lock_n1), 32'd1);
            check("masked_busy", 32'(busy1), 32'd0);
        end
        int1 = 1'b0;
        if_en = 1'b1;
        tick();

        // INT dropped one cycle into P1 does not abort.
        run_seq(1, 2, 2, 8'h0B, 1'b1);
        ack_vector(1);

        // Stray ACK while nothing is pending.
        ack1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_ack_valid", 32'(valid1), 32'd0);
            check("stray_ack_vector", 32'(vector1), 32'h0B);
            check("stray_ack_inta", 32'(inta1), 32'd1);
        end
        ack1 = 1'b0;

        // Asynchronous reset during GAP.
        data_in = 8'h77;
        int1 = 1'b1;
        repeat (3) tick();
        check("gap_inta", 32'(inta1), 32'd1);
        check("gap_lock_n", 32'(lock_n1), 32'd0);
        #2 rst_n = 1'b0;
        int1 = 1'b0;
        #1;
        check("async_rst_inta", 32'(inta1), 32'd1);
        check("async_rst_lock_n", 32'(lock_n1), 32'd1);
        check("async_rst_busy", 32'(busy1), 32'd0);
        check("async_rst_valid", 32'(valid1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_valid", 32'(valid1), 32'd0);
            check("post_rst_inta", 32'(inta1), 32'd1);
        end

        // Narrow pulse / wide gap instance.
        run_seq(2, 1, 3, 8'hA5, 1'b0);
        int2 = 1'b0;
        ack_vector(2);
        tick();
        check("dut2_idle_inta", 32'(inta2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
